ahb3lite_interconnect_master_port_v2: RTL and testbench

Next-generation master port (AHB slave side) of the AHB3-Lite multi-layer switch. It decodes each master transfer against SLAVES address windows and requests the addressed slave port. While the slave port is not granted, it holds the address phase and replays it on grant. It also enforces burst/lock-aware switch points. Generalised over previous generation: parametrised priority width and burst counter, deterministic multi-hit resolution, replay of any SEQ as NONSEQ, and an optional AHB decode-error responder.

---
 rtl/ahb3lite_interconnect_master_port_v2.sv | 251 +++++++++++++++++++++++++
 tb/tb_ahb3lite_interconnect_master_port_v2.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb3lite_interconnect_master_port_v2.sv
// AHB3-Lite multi-layer switch master port (the AHB slave side of the switch).
// It decodes each master transfer against the slave address windows and
// requests the addressed slave port. While that port is not granted, it holds
// the address phase and replays it on grant. It also reports burst/lock-aware
// switch points. A decode-error responder is built when
// AHB3LITE_MSTPORT_DECERR_EN is defined.
//
// state          | meaning
// NO_ACCESS      | no slave port requested; local zero-wait OKAY response
// ACCESS_PENDING | registered address phase held and replayed until granted
// ACCESS_GRANTED | slave port owns the data phase; live request forwarded
// DECERR1        | unmapped transfer, first error cycle (HREADYOUT=0, HRESP=1)
// DECERR2        | unmapped transfer, second error cycle (HREADYOUT=1, HRESP=1)
module ahb3lite_interconnect_master_port_v2 #(
   parameter int HADDR_SIZE     = 32,
   parameter int HDATA_SIZE     = 32,
   parameter int SLAVES         = 8,
   parameter int PRIORITY_BITS  = 3,
   parameter int BURST_CNT_BITS = 4
) (
   input  logic                         HCLK,
   input  logic                         HRESETn,
   input  logic [PRIORITY_BITS-1:0]     mst_priority,
   input  logic                         mst_HSEL,
   input  logic [HADDR_SIZE-1:0]        mst_HADDR,
   input  logic [HDATA_SIZE-1:0]        mst_HWDATA,
   input  logic                         mst_HWRITE,
   input  logic [2:0]                   mst_HSIZE,
   input  logic [2:0]                   mst_HBURST,
   input  logic [3:0]                   mst_HPROT,
   input  logic [1:0]                   mst_HTRANS,
   input  logic                         mst_HMASTLOCK,
   input  logic                         mst_HREADY,
   output logic [HDATA_SIZE-1:0]        mst_HRDATA,
   output logic                         mst_HREADYOUT,
   output logic                         mst_HRESP,
   input  logic [SLAVES*HADDR_SIZE-1:0] slvHADDRmask,
   input  logic [SLAVES*HADDR_SIZE-1:0] slvHADDRbase,
   output logic [SLAVES-1:0]            slvHSEL,
   output logic [HADDR_SIZE-1:0]        slvHADDR,
   output logic [HDATA_SIZE-1:0]        slvHWDATA,
   output logic                         slvHWRITE,
   output logic [2:0]                   slvHSIZE,
   output logic [2:0]                   slvHBURST,
   output logic [3:0]                   slvHPROT,
   output logic [1:0]                   slvHTRANS,
   output logic                         slvHMASTLOCK,
   input  logic [SLAVES*HDATA_SIZE-1:0] slvHRDATA,
   input  logic [SLAVES-1:0]            slvHREADY,
   input  logic [SLAVES-1:0]            slvHRESP,
   output logic                         slvHREADYOUT,
   output logic [PRIORITY_BITS-1:0]     slvpriority,
   output logic                         can_switch,
   input  logic [SLAVES-1:0]            master_granted,
   output logic                         decerr
);

   localparam int SEL_BITS = (SLAVES > 1) ? $clog2(SLAVES) : 1;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;
   localparam logic [2:0] HBURST_SINGLE = 3'b000;
   localparam logic [2:0] HBURST_INCR   = 3'b001;

   typedef enum logic [2:0] {
      NO_ACCESS,
      ACCESS_PENDING,
      ACCESS_GRANTED,
      DECERR1,
      DECERR2
   } state_t;

   state_t state, state_nxt;

   logic [PRIORITY_BITS-1:0]  reg_priority;
   logic [HADDR_SIZE-1:0]     reg_haddr;
   logic [HDATA_SIZE-1:0]     reg_hwdata;
   logic                      reg_hwrite;
   logic [2:0]                reg_hsize;
   logic [2:0]                reg_hburst;
   logic [3:0]                reg_hprot;
   logic [1:0]                reg_htrans;
   logic                      reg_hmastlock;
   logic                      local_ready;
   logic [SEL_BITS-1:0]       slave_sel;
   logic [SEL_BITS-1:0]       cur_idx, pend_idx, sel_idx;
   logic [SLAVES-1:0]         cur_hit, pend_hit;
   logic [BURST_CNT_BITS-1:0] burst_cnt;
   logic                      pend;
   logic                      addr_err;

   // Window decode of the live and the held request; lowest index wins on overlap.
   always_comb begin
      cur_hit  = '0;
      pend_hit = '0;
      cur_idx  = '0;
      pend_idx = '0;
      for (int s = SLAVES - 1; s >= 0; s--) begin
         if (mst_HTRANS != HTRANS_IDLE &&
             (mst_HADDR & slvHADDRmask[s*HADDR_SIZE +: HADDR_SIZE]) ==
             (slvHADDRbase[s*HADDR_SIZE +: HADDR_SIZE] & slvHADDRmask[s*HADDR_SIZE +: HADDR_SIZE])) begin
            cur_hit    = '0;
            cur_hit[s] = 1'b1;
            cur_idx    = SEL_BITS'(s);
         end
         if (reg_htrans != HTRANS_IDLE &&
             (reg_haddr & slvHADDRmask[s*HADDR_SIZE +: HADDR_SIZE]) ==
             (slvHADDRbase[s*HADDR_SIZE +: HADDR_SIZE] & slvHADDRmask[s*HADDR_SIZE +: HADDR_SIZE])) begin
            pend_hit    = '0;
            pend_hit[s] = 1'b1;
            pend_idx    = SEL_BITS'(s);
         end
      end
   end

`ifdef AHB3LITE_MSTPORT_DECERR_EN
   assign addr_err = mst_HREADY & mst_HSEL & (mst_HTRANS == HTRANS_NONSEQ || mst_HTRANS == HTRANS_SEQ) & ~|cur_hit;
   assign decerr   = (state == DECERR1);
`else
   assign addr_err = 1'b0;
   assign decerr   = 1'b0;
`endif

   // Capture the address phase, local ready, data-phase slave index and burst count on acceptance.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         reg_priority  <= '0;
         reg_haddr     <= '0;
         reg_hwdata    <= '0;
         reg_hwrite    <= 1'b0;
         reg_hsize     <= '0;
         reg_hburst    <= '0;
         reg_hprot     <= '0;
         reg_htrans    <= HTRANS_IDLE;
         reg_hmastlock <= 1'b0;
         local_ready   <= 1'b1;
         slave_sel     <= '0;
         burst_cnt     <= '0;
      end else if (mst_HREADY) begin
         reg_priority  <= mst_priority;
         reg_haddr     <= mst_HADDR;
         reg_hwdata    <= mst_HWDATA;
         reg_hwrite    <= mst_HWRITE;
         reg_hsize     <= mst_HSIZE;
         reg_hburst    <= mst_HBURST;
         reg_hprot     <= mst_HPROT;
         reg_htrans    <= mst_HSEL ? mst_HTRANS : HTRANS_IDLE;
         reg_hmastlock <= mst_HMASTLOCK;
         // an unmapped transfer is answered locally, so it must not stall the master
         local_ready   <= ~mst_HSEL | (mst_HTRANS == HTRANS_IDLE) | ~|cur_hit;
         slave_sel     <= sel_idx;
         if (mst_HSEL && mst_HTRANS == HTRANS_NONSEQ) begin
            case (mst_HBURST)
               3'b010, 3'b011: burst_cnt <= BURST_CNT_BITS'(2);
               3'b100, 3'b101: burst_cnt <= BURST_CNT_BITS'(6);
               3'b110, 3'b111: burst_cnt <= BURST_CNT_BITS'(14);
               default:        burst_cnt <= '0;
            endcase
         end else if (mst_HSEL && mst_HTRANS == HTRANS_SEQ && burst_cnt != '0) begin
            burst_cnt <= burst_cnt - BURST_CNT_BITS'(1);
         end
      end
   end

   // State register.
   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) state <= NO_ACCESS;
      else          state <= state_nxt;
   end

   // Next-state decision.
   always_comb begin
      state_nxt = state;
      case (state)
         NO_ACCESS, DECERR2: begin
            if (state == DECERR2) state_nxt = NO_ACCESS;
            if (addr_err)                state_nxt = DECERR1;
            else if (|cur_hit)           state_nxt = |(cur_hit & master_granted) ? ACCESS_GRANTED : ACCESS_PENDING;
            else if (|pend_hit)          state_nxt = ACCESS_PENDING;
         end
         ACCESS_PENDING: begin
            if (|(pend_hit & master_granted) && slvHREADY[slave_sel]) state_nxt = ACCESS_GRANTED;
         end
         ACCESS_GRANTED: begin
            if (mst_HREADY) begin
               if (addr_err)                     state_nxt = DECERR1;
               else if (~|cur_hit)               state_nxt = NO_ACCESS;
               else if (~|(cur_hit & master_granted) || ~|(cur_hit & slvHREADY))
                                                 state_nxt = ACCESS_PENDING;
            end
         end
         DECERR1: state_nxt = DECERR2;
         default: state_nxt = NO_ACCESS;
      endcase
   end

   // Request mux toward the slave ports: held request while pending, live otherwise.
   always_comb begin
      pend         = (state == ACCESS_PENDING);
      slvHSEL      = pend ? pend_hit : cur_hit;
      if (state == DECERR1) slvHSEL = '0;
      slvHADDR     = pend ? reg_haddr     : mst_HADDR;
      slvHWDATA    = pend ? reg_hwdata    : mst_HWDATA;
      slvHWRITE    = pend ? reg_hwrite    : mst_HWRITE;
      slvHSIZE     = pend ? reg_hsize     : mst_HSIZE;
      slvHBURST    = pend ? reg_hburst    : mst_HBURST;
      slvHPROT     = pend ? reg_hprot     : mst_HPROT;
      slvHMASTLOCK = pend ? reg_hmastlock : mst_HMASTLOCK;
      slvpriority  = pend ? reg_priority  : mst_priority;
      // a replayed beat starts a fresh address phase at the slave, so SEQ becomes NONSEQ
      slvHTRANS    = pend ? ((reg_htrans == HTRANS_SEQ) ? HTRANS_NONSEQ : reg_htrans) : mst_HTRANS;
      slvHREADYOUT = pend ? slvHREADY[slave_sel] : mst_HREADY;
      sel_idx      = pend ? pend_idx : cur_idx;
   end

   // Response mux toward the master.
   always_comb begin
      mst_HRDATA    = slvHRDATA[slave_sel*HDATA_SIZE +: HDATA_SIZE];
      mst_HREADYOUT = local_ready;
      mst_HRESP     = 1'b0;
      case (state)
         ACCESS_GRANTED: begin
            mst_HREADYOUT = slvHREADY[slave_sel];
            mst_HRESP     = slvHRESP[slave_sel];
         end
         DECERR1: begin
            mst_HREADYOUT = 1'b0;
            mst_HRESP     = 1'b1;
         end
         DECERR2: begin
            mst_HREADYOUT = 1'b1;
            mst_HRESP     = 1'b1;
         end
         default: ;
      endcase
   end

   // Switch points: never inside a locked sequence, fixed bursts only on their last beat.
   always_comb begin
      can_switch = 1'b1;
      if (state == ACCESS_GRANTED) begin
         can_switch = ~mst_HSEL |
                      (mst_HREADY & ~mst_HMASTLOCK &
                       ((mst_HTRANS == HTRANS_IDLE) ||
                        (mst_HTRANS == HTRANS_NONSEQ && (mst_HBURST == HBURST_SINGLE || mst_HBURST == HBURST_INCR)) ||
                        (mst_HTRANS == HTRANS_SEQ && mst_HBURST != HBURST_INCR && burst_cnt == '0)));
      end
   end

endmodule

// File: tb/tb_ahb3lite_interconnect_master_port_v2.sv
// Directed bench for ahb3lite_interconnect_master_port_v2. The master's HREADY
// is looped back from HREADYOUT, as with a single master on the layer.
module tb_ahb3lite_interconnect_master_port_v2;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int NS = 8;
   localparam int PB = 3;

   localparam logic [1:0] IDLE   = 2'b00;
   localparam logic [1:0] NONSEQ = 2'b10;
   localparam logic [1:0] SEQ    = 2'b11;
   localparam logic [2:0] SINGLE = 3'b000;
   localparam logic [2:0] INCR   = 3'b001;
   localparam logic [2:0] INCR8  = 3'b101;

   logic HCLK = 1'b0;
   logic HRESETn;
   always #5 HCLK = ~HCLK;

   logic [PB-1:0]    mst_priority;
   logic             mst_HSEL;
   logic [AW-1:0]    mst_HADDR;
   logic [DW-1:0]    mst_HWDATA;
   logic             mst_HWRITE;
   logic [2:0]       mst_HSIZE;
   logic [2:0]       mst_HBURST;
   logic [3:0]       mst_HPROT;
   logic [1:0]       mst_HTRANS;
   logic             mst_HMASTLOCK;
   logic             mst_HREADY;
   logic [DW-1:0]    mst_HRDATA;
   logic             mst_HREADYOUT;
   logic             mst_HRESP;
   logic [NS*AW-1:0] slvHADDRmask;
   logic [NS*AW-1:0] slvHADDRbase;
   logic [NS-1:0]    slvHSEL;
   logic [AW-1:0]    slvHADDR;
   logic [DW-1:0]    slvHWDATA;
   logic             slvHWRITE;
   logic [2:0]       slvHSIZE;
   logic [2:0]       slvHBURST;
   logic [3:0]       slvHPROT;
   logic [1:0]       slvHTRANS;
   logic             slvHMASTLOCK;
   logic [NS*DW-1:0] slvHRDATA;
   logic [NS-1:0]    slvHREADY;
   logic [NS-1:0]    slvHRESP;
   logic             slvHREADYOUT;
   logic [PB-1:0]    slvpriority;
   logic             can_switch;
   logic [NS-1:0]    master_granted;
   logic             decerr;

   assign mst_HREADY = mst_HREADYOUT;

   ahb3lite_interconnect_master_port_v2 #(
      .HADDR_SIZE(AW), .HDATA_SIZE(DW), .SLAVES(NS), .PRIORITY_BITS(PB), .BURST_CNT_BITS(4)
   ) dut (
      .HCLK(HCLK), .HRESETn(HRESETn),
      .mst_priority(mst_priority), .mst_HSEL(mst_HSEL), .mst_HADDR(mst_HADDR),
      .mst_HWDATA(mst_HWDATA), .mst_HWRITE(mst_HWRITE), .mst_HSIZE(mst_HSIZE),
      .mst_HBURST(mst_HBURST), .mst_HPROT(mst_HPROT), .mst_HTRANS(mst_HTRANS),
      .mst_HMASTLOCK(mst_HMASTLOCK), .mst_HREADY(mst_HREADY), .mst_HRDATA(mst_HRDATA),
      .mst_HREADYOUT(mst_HREADYOUT), .mst_HRESP(mst_HRESP),
      .slvHADDRmask(slvHADDRmask), .slvHADDRbase(slvHADDRbase), .slvHSEL(slvHSEL),
      .slvHADDR(slvHADDR), .slvHWDATA(slvHWDATA), .slvHWRITE(slvHWRITE),
      .slvHSIZE(slvHSIZE), .slvHBURST(slvHBURST), .slvHPROT(slvHPROT),
      .slvHTRANS(slvHTRANS), .slvHMASTLOCK(slvHMASTLOCK), .slvHRDATA(slvHRDATA),
      .slvHREADY(slvHREADY), .slvHRESP(slvHRESP), .slvHREADYOUT(slvHREADYOUT),
      .slvpriority(slvpriority), .can_switch(can_switch),
      .master_granted(master_granted), .decerr(decerr)
   );

   int n_checks;
   int n_pass;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   task automatic cyc();
      @(posedge HCLK);
      #1;
   endtask

   task automatic drive(input logic [1:0] t, input logic [31:0] a, input logic [2:0] b);
      mst_HTRANS = t;
      mst_HADDR  = a;
      mst_HBURST = b;
   endtask

   initial begin
      n_checks = 0;
      n_pass   = 0;
      for (int s = 0; s < NS; s++) begin
         slvHADDRmask[s*AW +: AW] = 32'hF000_0000;
         slvHADDRbase[s*AW +: AW] = AW'(s) << 28;
         slvHRDATA[s*DW +: DW]    = 32'hD000_0000 | DW'(s);
      end
      // window 0 overlaps window 2 to exercise lowest-index resolution
      slvHADDRbase[0 +: AW] = 32'h2000_0000;
      slvHREADY      = '1;
      slvHRESP       = '0;
      master_granted = '1;
      mst_priority   = 3'd5;
      mst_HSEL       = 1'b1;
      mst_HWDATA     = 32'hCAFE_0000;
      mst_HWRITE     = 1'b1;
      mst_HSIZE      = 3'd2;
      mst_HPROT      = 4'b0011;
      mst_HMASTLOCK  = 1'b0;
      drive(IDLE, 32'h0, SINGLE);
      HRESETn = 1'b0;

      // reset state
      repeat (2) @(posedge HCLK);
      #2;
      chk("rst_readyout", 32'(mst_HREADYOUT), 32'h1);
      chk("rst_resp",     32'(mst_HRESP),     32'h0);
      chk("rst_hsel",     32'(slvHSEL),       32'h0);
      chk("rst_decerr",   32'(decerr),        32'h0);
      cyc();
      HRESETn = 1'b1;

      // single write to slave 1, granted immediately
      cyc();
      drive(NONSEQ, 32'h1000_0000, SINGLE);
      #1;
      chk("single_hsel",  32'(slvHSEL),     32'h02);
      chk("single_haddr", 32'(slvHADDR),    32'h1000_0000);
      chk("single_prio",  32'(slvpriority), 32'h5);
      cyc();
      drive(IDLE, 32'h0, SINGLE);
      slvHREADY[1] = 1'b0;
      #1;
      chk("single_wait_readyout",   32'(mst_HREADYOUT), 32'h0);
      chk("single_wait_can_switch", 32'(can_switch),    32'h0);
      slvHREADY[1] = 1'b1;
      #1;
      chk("single_readyout",   32'(mst_HREADYOUT), 32'h1);
      chk("single_rdata",      32'(mst_HRDATA),    32'hD000_0001);
      chk("single_can_switch", 32'(can_switch),    32'h1);

      // INCR burst loses its grant on the SEQ beat: hold and replay as NONSEQ
      cyc();
      drive(NONSEQ, 32'h1000_0000, INCR);
      cyc();
      drive(SEQ, 32'h1000_0004, INCR);
      master_granted = '0;
      #1;
      chk("incr_seq_can_switch", 32'(can_switch), 32'h0);
      cyc();
      drive(IDLE, 32'h0, SINGLE);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk("pend_htrans",   32'(slvHTRANS),     32'(NONSEQ));
         chk("pend_haddr",    32'(slvHADDR),      32'h1000_0004);
         chk("pend_hsel",     32'(slvHSEL),       32'h02);
         chk("pend_readyout", 32'(mst_HREADYOUT), 32'h0);
         cyc();
         #1;
      end
      master_granted = 8'h02;
      #1;
      chk("pend_slv_readyout", 32'(slvHREADYOUT), 32'h1);
      cyc();
      #1;
      chk("regrant_readyout", 32'(mst_HREADYOUT), 32'h1);
      chk("regrant_htrans",   32'(slvHTRANS),     32'(IDLE));
      master_granted = '1;

      // unlocked INCR8 starting back-to-back from a granted single
      cyc();
      drive(NONSEQ, 32'h1000_0000, SINGLE);
      cyc();
      drive(NONSEQ, 32'h1000_0000, INCR8);
      #1;
      chk("incr8_beat1_can_switch", 32'(can_switch), 32'h0);
      for (int b = 2; b <= 8; b++) begin
         cyc();
         drive(SEQ, 32'h1000_0000 + 32'(4 * (b - 1)), INCR8);
         #1;
         chk((b == 8) ? "incr8_last_can_switch" : "incr8_mid_can_switch",
             32'(can_switch), 32'(b == 8));
      end
      cyc();
      drive(IDLE, 32'h0, SINGLE);

      // overlapping windows 0 and 2
      cyc();
      drive(NONSEQ, 32'h2000_0000, SINGLE);
      #1;
      chk("multihit_hsel", 32'(slvHSEL), 32'h01);
      cyc();
      drive(IDLE, 32'h0, SINGLE);
      #1;
      chk("multihit_rdata", 32'(mst_HRDATA), 32'hD000_0000);

      // unmapped address
      cyc();
      drive(NONSEQ, 32'hF000_0000, SINGLE);
      #1;
      chk("unmapped_hsel", 32'(slvHSEL), 32'h0);
      cyc();
      drive(IDLE, 32'h0, SINGLE);
      #1;
`ifdef AHB3LITE_MSTPORT_DECERR_EN
      chk("decerr1_readyout", 32'(mst_HREADYOUT), 32'h0);
      chk("decerr1_resp",     32'(mst_HRESP),     32'h1);
      chk("decerr1_pulse",    32'(decerr),        32'h1);
      chk("decerr1_hsel",     32'(slvHSEL),       32'h0);
      cyc();
      #1;
      chk("decerr2_readyout", 32'(mst_HREADYOUT), 32'h1);
      chk("decerr2_resp",     32'(mst_HRESP),     32'h1);
      chk("decerr2_pulse",    32'(decerr),        32'h0);
`else
      chk("unmapped_readyout", 32'(mst_HREADYOUT), 32'h1);
      chk("unmapped_resp",     32'(mst_HRESP),     32'h0);
      chk("unmapped_decerr",   32'(decerr),        32'h0);
`endif
      cyc();

      // reset while pending aborts the held transfer
      cyc();
      master_granted = '0;
      drive(NONSEQ, 32'h3000_0000, SINGLE);
      cyc();
      drive(IDLE, 32'h0, SINGLE);
      #1;
      chk("rstpend_readyout", 32'(mst_HREADYOUT), 32'h0);
      chk("rstpend_hsel",     32'(slvHSEL),       32'h08);
      HRESETn = 1'b0;
      #1;
      chk("rstpend_rst_readyout", 32'(mst_HREADYOUT), 32'h1);
      chk("rstpend_rst_resp",     32'(mst_HRESP),     32'h0);
      chk("rstpend_rst_hsel",     32'(slvHSEL),       32'h0);
      cyc();
      master_granted = '1;
      HRESETn = 1'b1;
      cyc();
      #1;
      chk("noreplay_hsel",     32'(slvHSEL),       32'h0);
      chk("noreplay_htrans",   32'(slvHTRANS),     32'(IDLE));
      chk("noreplay_readyout", 32'(mst_HREADYOUT), 32'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
